// File: rtl/ternary_serial_subtractor_8trit.sv
// ternary_serial_subtractor_8trit: bit-serial balanced-ternary a - b + cin, one trit per cycle, LST first.
// Trit encoding: 00 = zero, 01 = +1, 10 = -1, 11 = illegal.
package ternary_pkg;
    typedef logic [1:0] trit_t;
    localparam trit_t T_ZERO = 2'b00;
    localparam trit_t T_POS  = 2'b01;
    localparam trit_t T_NEG  = 2'b10;
endpackage

module ternary_serial_subtractor_8trit
    import ternary_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  trit_t [7:0] a,
    input  trit_t [7:0] b,
    input  trit_t       cin,
    output logic        out_valid,
    input  logic        out_ready,
    output trit_t [7:0] diff,
    output trit_t       cout,
    output logic        zero,
    output trit_t       sign,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [2:0]  i;
    trit_t [7:0] a_r, b_r;
    trit_t       carry, s, nc;
    logic signed [2:0] t;
    logic        bad;

    // Illegal codes decode to 0, so they drop out of the arithmetic naturally.
    function automatic logic signed [2:0] val(input trit_t x);
        return x == T_POS ? 3'sd1 : x == T_NEG ? -3'sd1 : 3'sd0;
    endfunction

    always_comb begin
        t = val(a_r[i]) - val(b_r[i]) + val(carry);
        nc = t > 3'sd1 ? T_POS : t < -3'sd1 ? T_NEG : T_ZERO;
        s = (t == 3'sd1 || t == -3'sd2) ? T_POS : (t == -3'sd1 || t == 3'sd2) ? T_NEG : T_ZERO;
    end

    always_comb begin
        bad = 1'b0;
        for (int k = 0; k < 8; k++) bad = bad | (a[k] == 2'b11) | (b[k] == 2'b11);
    end

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign zero      = diff == '0 && cout == T_ZERO;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            i     <= '0;
            carry <= T_ZERO;
            diff  <= '0;
            cout  <= T_ZERO;
            sign  <= T_ZERO;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_r   <= a;
                    b_r   <= b;
                    carry <= cin;
                    i     <= '0;
                    diff  <= '0;
                    cout  <= T_ZERO;
                    sign  <= T_ZERO;
                    err   <= bad;
                    state <= RUN;
                end
                RUN: begin
                    diff[i] <= s;
                    carry   <= nc;
                    i       <= i + 3'd1;
                    if (s != T_ZERO) sign <= s;
                    // The final carry is the most significant trit, so it overrides sign last.
                    if (i == 3'd7) begin
                        cout  <= nc;
                        state <= DONE;
                        if (nc != T_ZERO) sign <= nc;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ternary_serial_subtractor_8trit.sv
// tb_ternary_serial_subtractor_8trit: randomized and directed checks against an integer reference model.
module tb_ternary_serial_subtractor_8trit;
    import ternary_pkg::*;
    typedef trit_t [7:0] word_t;

    logic  clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
    logic  in_ready, out_valid, zero, err;
    word_t a = '0, b = '0, diff;
    trit_t cin = T_ZERO, cout, sign;

    int checks = 0, errors = 0;

    word_t got_diff, exp_diff;
    trit_t got_cout, got_sign, exp_cout, exp_sign;
    logic  got_zero, got_err, exp_zero, exp_err;
    logic  stable, ready_accept, ready_done, ready_after, valid_after;
    int    lat;

    ternary_serial_subtractor_8trit dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .cout(cout), .zero(zero), .sign(sign), .err(err)
    );

    always #5 clk = ~clk;

    function automatic int tval(trit_t x);
        return x == T_POS ? 1 : x == T_NEG ? -1 : 0;
    endfunction

    function automatic trit_t enc(int d);
        return d > 0 ? T_POS : d < 0 ? T_NEG : T_ZERO;
    endfunction

    function automatic int to_int(word_t w);
        int v = 0;
        for (int k = 7; k >= 0; k--) v = v * 3 + tval(w[k]);
        return v;
    endfunction

    function automatic word_t to_word(int v);
        word_t w;
        int r, d;
        for (int k = 0; k < 8; k++) begin
            r = ((v % 3) + 3) % 3;
            d = r == 2 ? -1 : r;
            w[k] = enc(d);
            v = (v - d) / 3;
        end
        return w;
    endfunction

    function automatic word_t rnd_word();
        return to_word(int'($urandom_range(0, 6560)) - 3280);
    endfunction

    // Reference: integer result re-expressed as 9 balanced trits.
    task automatic model(input word_t av, input word_t bv, input trit_t cv);
        int r, m, d;
        r = to_int(av) - to_int(bv) + tval(cv);
        exp_zero = r == 0;
        exp_sign = enc(r);
        exp_err = 1'b0;
        for (int k = 0; k < 8; k++) exp_err |= (av[k] == 2'b11) | (bv[k] == 2'b11);
        for (int k = 0; k < 9; k++) begin
            m = ((r % 3) + 3) % 3;
            d = m == 2 ? -1 : m;
            if (k < 8) exp_diff[k] = enc(d);
            else exp_cout = enc(d);
            r = (r - d) / 3;
        end
    endtask

    task automatic do_op(input word_t av, input word_t bv, input trit_t cv, input int hold, input bit noise);
        @(negedge clk);
        a = av; b = bv; cin = cv; in_valid = 1;
        ready_accept = in_ready;
        @(negedge clk);
        in_valid = noise; a = rnd_word(); b = rnd_word(); cin = T_POS;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        in_valid = 0;
        got_diff = diff; got_cout = cout; got_sign = sign; got_zero = zero; got_err = err;
        stable = 1; ready_done = in_ready;
        repeat (hold) begin
            @(negedge clk);
            if ({diff, cout, sign, zero, err, out_valid} !== {got_diff, got_cout, got_sign, got_zero, got_err, 1'b1}) stable = 0;
            ready_done |= in_ready;
        end
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        ready_after = in_ready; valid_after = out_valid;
    endtask

    task automatic test_reset();
        checks++;
        if ({in_ready, out_valid, diff, cout, sign, zero, err} !== {1'b1, 1'b0, 16'h0, T_ZERO, T_ZERO, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b diff=%h cout=%h sign=%h zero=%b err=%b expected 1 0 0000 0 0 1 0",
                     in_ready, out_valid, diff, cout, sign, zero, err);
        end
    endtask

    task automatic test_directed();
        word_t va[5], vb[5], ill;
        trit_t vc[5];
        int    vh[5];
        ill = '0; ill[3] = 2'b11;
        va[0] = to_word(5);    vb[0] = to_word(3);     vc[0] = T_ZERO; vh[0] = 0;
        va[1] = to_word(100);  vb[1] = to_word(100);   vc[1] = T_ZERO; vh[1] = 2;
        va[2] = to_word(3280); vb[2] = to_word(-3280); vc[2] = T_POS;  vh[2] = 1;
        va[3] = to_word(-7);   vb[3] = to_word(2);     vc[3] = T_ZERO; vh[3] = 5;
        va[4] = ill;           vb[4] = to_word(1);     vc[4] = T_ZERO; vh[4] = 0;
        for (int n = 0; n < 5; n++) begin
            model(va[n], vb[n], vc[n]);
            do_op(va[n], vb[n], vc[n], vh[n], 1'b0);
            checks += 4;
            if (lat !== 9) begin
                errors++; $display("FAIL dir%0d latency got %0d expected 9", n, lat);
            end
            if (got_diff !== exp_diff) begin
                errors++; $display("FAIL dir%0d diff got %h expected %h", n, got_diff, exp_diff);
            end
            if ({got_cout, got_sign, got_zero, got_err} !== {exp_cout, exp_sign, exp_zero, exp_err}) begin
                errors++;
                $display("FAIL dir%0d flags cout/sign/zero/err got %h/%h/%b/%b expected %h/%h/%b/%b",
                         n, got_cout, got_sign, got_zero, got_err, exp_cout, exp_sign, exp_zero, exp_err);
            end
            if ({ready_accept, stable, ready_done, ready_after, valid_after} !== 5'b11010) begin
                errors++;
                $display("FAIL dir%0d handshake acc/stable/rdy_done/rdy_after/vld_after got %b%b%b%b%b expected 11010",
                         n, ready_accept, stable, ready_done, ready_after, valid_after);
            end
            repeat (2) @(negedge clk);
            checks++;
            if ({diff, cout, sign, zero, err} !== {got_diff, got_cout, got_sign, got_zero, got_err}) begin
                errors++; $display("FAIL dir%0d post-handshake hold diff got %h expected %h", n, diff, got_diff);
            end
        end
    endtask

    task automatic test_random();
        word_t av, bv;
        trit_t cv;
        for (int n = 0; n < 25; n++) begin
            av = rnd_word(); bv = rnd_word();
            if ($urandom_range(0, 4) == 0) av[$urandom_range(0, 7)] = 2'b11;
            cv = enc(int'($urandom_range(0, 2)) - 1);
            model(av, bv, cv);
            do_op(av, bv, cv, int'($urandom_range(0, 3)), 1'b0);
            checks++;
            if ({lat, got_diff, got_cout, got_sign, got_zero, got_err, stable} !==
                {32'd9, exp_diff, exp_cout, exp_sign, exp_zero, exp_err, 1'b1}) begin
                errors++;
                $display("FAIL rand%0d lat=%0d diff=%h cout=%h sign=%h zero=%b err=%b stable=%b expected lat=9 diff=%h cout=%h sign=%h zero=%b err=%b",
                         n, lat, got_diff, got_cout, got_sign, got_zero, got_err, stable,
                         exp_diff, exp_cout, exp_sign, exp_zero, exp_err);
            end
        end
    endtask

    task automatic test_back_to_back();
        word_t av, bv;
        for (int n = 0; n < 6; n++) begin
            av = rnd_word(); bv = rnd_word();
            model(av, bv, T_NEG);
            do_op(av, bv, T_NEG, 0, 1'b1);
            checks++;
            if ({lat, got_diff, got_cout, got_sign, got_zero, ready_after} !==
                {32'd9, exp_diff, exp_cout, exp_sign, exp_zero, 1'b1}) begin
                errors++;
                $display("FAIL b2b%0d lat=%0d diff=%h cout=%h sign=%h rdy_after=%b expected lat=9 diff=%h cout=%h sign=%h rdy_after=1",
                         n, lat, got_diff, got_cout, got_sign, ready_after, exp_diff, exp_cout, exp_sign);
            end
        end
    endtask

    task automatic test_mid_reset();
        int w;
        @(negedge clk);
        a = to_word(1234); b = to_word(-55); cin = T_POS; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        repeat (3) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        test_reset();
        repeat (12) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL midrun discard vld=%b rdy=%b expected 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        a = to_word(-999); b = to_word(7); cin = T_ZERO; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        w = 0;
        while (!out_valid && w < 40) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL done-reset setup out_valid got %b expected 1", out_valid);
        end
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        test_reset();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
